// File: rtl/syn_pcm_pkg.sv
// Shared types and helpers for the multi-channel PCM ping-pong buffer.
package syn_pcm_pkg;
  typedef enum logic [1:0] {IDLE, FILL, WAIT} wr_fsm_t;

  localparam int PCM_NUM_BANKS = 2;

  // Linear word address: banks hold NUM_CHNNLS contiguous channel regions of 2^depth_w frames.
  function automatic int unsigned pcm_mem_addr(input int unsigned bank, input int unsigned ch,
                                               input int unsigned addr, input int unsigned num_chnnls,
                                               input int unsigned depth_w);
    return ((bank * num_chnnls + ch) << depth_w) + addr;
  endfunction
endpackage

// File: rtl/syn_pcm_dpram.sv
// Simple dual-port RAM: one write port, one registered read port; same-address read returns old data.
module syn_pcm_dpram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/syn_pcm_mchnnl_buf.sv
// Multi-channel ping-pong PCM buffer: interleaved capture into two banks, per-bank
// ready/ack handoff to the FFT consumer, frame resync and sticky overflow.
module syn_pcm_mchnnl_buf
  import syn_pcm_pkg::*;
#(
  parameter  int NUM_CHNNLS = 2,
  parameter  int SAMPLE_W   = 32,
  parameter  int DEPTH_W    = 7,
  localparam int CHNNL_W    = (NUM_CHNNLS > 1) ? $clog2(NUM_CHNNLS) : 1
) (
  input  logic                clk_ir,
  input  logic                rst_il,
  input  logic                en,
  input  logic                wr_valid,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                frame_sync,
  output logic [1:0]          bank_rdy,
  input  logic [1:0]          bank_ack,
  output logic                wr_bank,
  output logic                ovrflw,
  input  logic                ovrflw_clr,
  input  logic                rd_en,
  input  logic                rd_bank,
  input  logic [CHNNL_W-1:0]  rd_chnnl,
  input  logic [DEPTH_W-1:0]  rd_addr,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                rd_valid
);
  localparam int WORDS = PCM_NUM_BANKS * NUM_CHNNLS * (2**DEPTH_W);
  localparam int AW    = $clog2(WORDS);
  localparam logic [CHNNL_W-1:0] LAST_CH = CHNNL_W'(NUM_CHNNLS - 1);

  wr_fsm_t              state, state_nxt;
  logic [CHNNL_W-1:0]   chnnl_cnt, ch;
  logic [DEPTH_W-1:0]   addr_cnt;
  logic [1:0]           bank_rdy_nxt;
  logic                 cur_rdy, accept, drop, last_ch, bank_done;
  logic                 rd_oob, rd_oob_q;
  logic [AW-1:0]        waddr, raddr;
  logic [SAMPLE_W-1:0]  ram_q;

  assign cur_rdy   = bank_rdy[wr_bank];
  assign accept    = en && wr_valid && (state == FILL) && !cur_rdy;
  assign drop      = en && wr_valid && ((state == WAIT) || ((state == FILL) && cur_rdy));
  // frame_sync forces ch0, so a mid-frame sync rewrites the partial frame in place.
  assign ch        = frame_sync ? '0 : chnnl_cnt;
  assign last_ch   = (ch == LAST_CH);
  assign bank_done = accept && last_ch && (&addr_cnt);

  always_comb begin
    state_nxt = state;
    if (!en) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    state_nxt = FILL;
        FILL:    if (cur_rdy)  state_nxt = WAIT;
        WAIT:    if (!cur_rdy) state_nxt = FILL;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bank_rdy_nxt = bank_rdy & ~bank_ack;
    if (bank_done) bank_rdy_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state     <= IDLE;
      chnnl_cnt <= '0;
      addr_cnt  <= '0;
      wr_bank   <= 1'b0;
      bank_rdy  <= '0;
      ovrflw    <= 1'b0;
    end else begin
      state    <= state_nxt;
      bank_rdy <= bank_rdy_nxt;
      if (accept) begin
        if (last_ch) begin
          chnnl_cnt <= '0;
          addr_cnt  <= addr_cnt + 1'b1;
          if (&addr_cnt) wr_bank <= ~wr_bank;
        end else begin
          chnnl_cnt <= ch + 1'b1;
        end
      end
      if (drop)            ovrflw <= 1'b1;
      else if (ovrflw_clr) ovrflw <= 1'b0;
    end
  end

  assign rd_oob = (32'(rd_chnnl) >= NUM_CHNNLS);
  assign waddr  = AW'(pcm_mem_addr(32'(wr_bank), 32'(ch), 32'(addr_cnt), NUM_CHNNLS, DEPTH_W));
  assign raddr  = AW'(pcm_mem_addr(32'(rd_bank), rd_oob ? 32'd0 : 32'(rd_chnnl), 32'(rd_addr),
                                   NUM_CHNNLS, DEPTH_W));

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      rd_valid <= 1'b0;
      rd_oob_q <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_oob_q <= rd_oob;
    end
  end

  assign rd_data = rd_oob_q ? '0 : ram_q;

  syn_pcm_dpram #(.DATA_W(SAMPLE_W), .ADDR_W(AW), .DEPTH(WORDS)) u_ram (
    .clk   (clk_ir),
    .rst_n (rst_il),
    .we    (accept),
    .waddr (waddr),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (raddr),
    .rdata (ram_q)
  );
endmodule

// File: tb/tb_syn_pcm_mchnnl_buf.sv
// Bench: a 2-channel and a 3-channel buffer share stimulus; both are compared every cycle
// against a frame/bank-level reference model, plus directed scenario checks.
module tb_syn_pcm_mchnnl_buf;
  localparam int SW = 32;
  localparam int DW = 2;
  localparam int FR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, wr_valid = 1'b0, frame_sync = 1'b0, ovrflw_clr = 1'b0;
  logic rd_en = 1'b0, rd_bank = 1'b0;
  logic [SW-1:0] wr_data = '0;
  logic [1:0]    bank_ack = '0;
  logic [DW-1:0] rd_addr = '0;
  logic          rd_chnnl_a = 1'b0;
  logic [1:0]    rd_chnnl_b = '0;

  logic [1:0]    o_rdy [2];
  logic          o_wb  [2];
  logic          o_ov  [2];
  logic          o_rv  [2];
  logic [SW-1:0] o_rd  [2];

  always #5 clk = ~clk;

  syn_pcm_mchnnl_buf #(.NUM_CHNNLS(2), .SAMPLE_W(SW), .DEPTH_W(DW)) u_a (
    .clk_ir(clk), .rst_il(rst_n), .en(en), .wr_valid(wr_valid), .wr_data(wr_data),
    .frame_sync(frame_sync), .bank_rdy(o_rdy[0]), .bank_ack(bank_ack), .wr_bank(o_wb[0]),
    .ovrflw(o_ov[0]), .ovrflw_clr(ovrflw_clr), .rd_en(rd_en), .rd_bank(rd_bank),
    .rd_chnnl(rd_chnnl_a), .rd_addr(rd_addr), .rd_data(o_rd[0]), .rd_valid(o_rv[0]));

  syn_pcm_mchnnl_buf #(.NUM_CHNNLS(3), .SAMPLE_W(SW), .DEPTH_W(DW)) u_b (
    .clk_ir(clk), .rst_il(rst_n), .en(en), .wr_valid(wr_valid), .wr_data(wr_data),
    .frame_sync(frame_sync), .bank_rdy(o_rdy[1]), .bank_ack(bank_ack), .wr_bank(o_wb[1]),
    .ovrflw(o_ov[1]), .ovrflw_clr(ovrflw_clr), .rd_en(rd_en), .rd_bank(rd_bank),
    .rd_chnnl(rd_chnnl_b), .rd_addr(rd_addr), .rd_data(o_rd[1]), .rd_valid(o_rv[1]));

  // Reference model state: mode 0=idle 1=filling 2=waiting for a free bank
  int            nch   [2] = '{2, 3};
  int            mmode [2];
  int            mch   [2];
  int            maddr [2];
  bit            mbank [2];
  bit [1:0]      mrdy  [2];
  bit            mov   [2];
  bit            mrv   [2];
  bit            mchk  [2];
  logic [SW-1:0] mrd   [2];
  logic [SW-1:0] mmem  [2][2][4][FR];
  bit            mval  [2][2][4][FR];

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mmode[i] = 0; mch[i] = 0; maddr[i] = 0; mbank[i] = 1'b0; mrdy[i] = 2'b00;
      mov[i] = 1'b0; mrv[i] = 1'b0; mrd[i] = '0; mchk[i] = 1'b1;
    end
  endtask

  task automatic model_step(input int i);
    int n, c, rc, ra, nmode;
    bit acc, drp, full;
    bit [1:0] nrdy;
    n  = nch[i];
    rc = (i == 0) ? int'(rd_chnnl_a) : int'(rd_chnnl_b);
    ra = int'(rd_addr);
    // read observes memory before this cycle's write
    if (rd_en) begin
      mrv[i] = 1'b1;
      if (rc >= n) begin
        mrd[i] = '0; mchk[i] = 1'b1;
      end else begin
        mrd[i]  = mmem[i][rd_bank][rc][ra];
        mchk[i] = mval[i][rd_bank][rc][ra] && (mrdy[i][rd_bank] || (rd_bank != mbank[i]));
      end
    end else mrv[i] = 1'b0;
    full = mrdy[i][mbank[i]];
    acc  = en && wr_valid && (mmode[i] == 1) && !full;
    drp  = en && wr_valid && ((mmode[i] == 2) || ((mmode[i] == 1) && full));
    nrdy = mrdy[i] & ~bank_ack;
    if (!en) nmode = 0;
    else if (mmode[i] == 0) nmode = 1;
    else nmode = full ? 2 : 1;
    if (acc) begin
      c = frame_sync ? 0 : mch[i];
      mmem[i][mbank[i]][c][maddr[i]] = wr_data;
      mval[i][mbank[i]][c][maddr[i]] = 1'b1;
      if (c == n - 1) begin
        mch[i] = 0;
        if (maddr[i] == FR - 1) begin
          nrdy[mbank[i]] = 1'b1;
          mbank[i] = ~mbank[i];
          maddr[i] = 0;
        end else maddr[i]++;
      end else mch[i] = c + 1;
    end
    if (drp) mov[i] = 1'b1;
    else if (ovrflw_clr) mov[i] = 1'b0;
    mrdy[i]  = nrdy;
    mmode[i] = nmode;
  endtask

  task automatic tick();
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end else model_reset();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rdy%0d", i), 32'(o_rdy[i]), 32'(mrdy[i]));
      chk($sformatf("wbank%0d", i), 32'(o_wb[i]), 32'(mbank[i]));
      chk($sformatf("ovrflw%0d", i), 32'(o_ov[i]), 32'(mov[i]));
      chk($sformatf("rvalid%0d", i), 32'(o_rv[i]), 32'(mrv[i]));
      if (mchk[i]) chk($sformatf("rdata%0d", i), o_rd[i], mrd[i]);
    end
  endtask

  task automatic idle();
    wr_valid = 1'b0; frame_sync = 1'b0; bank_ack = 2'b00; ovrflw_clr = 1'b0; rd_en = 1'b0;
  endtask

  task automatic send(input logic [SW-1:0] d, input logic fs);
    wr_valid = 1'b1; wr_data = d; frame_sync = fs;
    tick();
    idle();
  endtask

  task automatic rd(input logic b, input logic [1:0] c, input logic [1:0] a);
    rd_en = 1'b1; rd_bank = b; rd_chnnl_a = c[0]; rd_chnnl_b = c; rd_addr = a;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    en = 1'b0; rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_rdy", 32'(o_rdy[0]), 32'd0);
    chk("rst_rdata", o_rd[0], 32'd0);

    // 1: single bank fill, then read back
    en = 1'b1; tick();
    for (int k = 0; k < 8; k++) send(SW'(k), (k % 2) == 0);
    chk("t1_rdy", 32'(o_rdy[0]), 32'd1);
    chk("t1_wbank", 32'(o_wb[0]), 32'd1);
    rd(1'b0, 2'd1, 2'd3);
    chk("t1_rvalid", 32'(o_rv[0]), 32'd1);
    chk("t1_ch1a3", o_rd[0], 32'd7);
    rd(1'b0, 2'd0, 2'd2);
    chk("t1_ch0a2", o_rd[0], 32'd4);
    tick();
    chk("t1_rvalid_low", 32'(o_rv[0]), 32'd0);
    chk("t1_hold", o_rd[0], 32'd4);

    // 2: both banks full, overflow, partial release
    for (int k = 8; k < 16; k++) send(SW'(k), (k % 2) == 0);
    chk("t2_rdy11", 32'(o_rdy[0]), 32'd3);
    send(32'd16, 1'b1);
    chk("t2_ovrflw", 32'(o_ov[0]), 32'd1);
    send(32'd17, 1'b0);
    rd(1'b0, 2'd0, 2'd0);
    chk("t2_nowrite", o_rd[0], 32'd0);
    bank_ack = 2'b01; tick(); idle();
    chk("t2_ack", 32'(o_rdy[0]), 32'd2);
    tick();
    send(32'd20, 1'b1); send(32'd21, 1'b0);
    rd(1'b0, 2'd0, 2'd0);
    chk("t2_b0a0c0", o_rd[0], 32'd20);
    rd(1'b0, 2'd1, 2'd0);
    chk("t2_b0a0c1", o_rd[0], 32'd21);
    ovrflw_clr = 1'b1; tick(); idle();
    chk("t2_ovclr", 32'(o_ov[0]), 32'd0);

    // 3: mid-frame resync
    do_reset(); en = 1'b1; tick();
    send(32'hA, 1'b1); send(32'hB, 1'b1); send(32'hC, 1'b0); send(32'hD, 1'b1);
    rd(1'b0, 2'd0, 2'd0); chk("t3_ch0", o_rd[0], 32'hB);
    rd(1'b0, 2'd1, 2'd0); chk("t3_ch1", o_rd[0], 32'hC);
    rd(1'b0, 2'd0, 2'd1); chk("t3_addr1", o_rd[0], 32'hD);

    // 4: enable gating keeps the partial frame
    do_reset(); en = 1'b1; tick();
    send(32'd40, 1'b1); send(32'd41, 1'b0); send(32'd42, 1'b1);
    en = 1'b0; tick();
    for (int k = 0; k < 5; k++) send(SW'(50 + k), k == 0);
    chk("t4_noov", 32'(o_ov[0]), 32'd0);
    en = 1'b1; tick();
    send(32'd60, 1'b0);
    rd(1'b0, 2'd1, 2'd1); chk("t4_ch1a1", o_rd[0], 32'd60);
    rd(1'b0, 2'd0, 2'd1); chk("t4_ch0a1", o_rd[0], 32'd42);

    // 5: async reset mid-fill
    do_reset(); en = 1'b1; tick();
    for (int k = 0; k < 13; k++) send(SW'(70 + k), (k % 2) == 0);
    rd(1'b1, 2'd0, 2'd0);
    chk("t5_pre_wb", 32'(o_wb[0]), 32'd1);
    rd_en = 1'b1; rst_n = 1'b0; tick(); tick();
    chk("t5_rdy", 32'(o_rdy[0]), 32'd0);
    chk("t5_wb", 32'(o_wb[0]), 32'd0);
    chk("t5_rv", 32'(o_rv[0]), 32'd0);
    chk("t5_rd", o_rd[0], 32'd0);
    idle(); rst_n = 1'b1; tick();
    send(32'd80, 1'b0);
    rd(1'b0, 2'd0, 2'd0); chk("t5_restart", o_rd[0], 32'd80);

    // 6: three channels, out-of-range channel read
    do_reset(); en = 1'b1; tick();
    for (int k = 0; k < 12; k++) send(SW'(k), (k % 3) == 0);
    chk("t6_rdy", 32'(o_rdy[1]), 32'd1);
    rd(1'b0, 2'd2, 2'd3); chk("t6_ch2a3", o_rd[1], 32'd11);
    rd(1'b0, 2'd1, 2'd2); chk("t6_ch1a2", o_rd[1], 32'd7);
    rd(1'b0, 2'd3, 2'd0); chk("t6_oob", o_rd[1], 32'd0);

    // randomized traffic against the model
    do_reset(); en = 1'b1; tick();
    repeat (3000) begin
      en         = ($urandom_range(0, 63) != 0);
      wr_valid   = 1'($urandom_range(0, 1));
      wr_data    = $urandom;
      frame_sync = ($urandom_range(0, 3) == 0);
      bank_ack   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ovrflw_clr = ($urandom_range(0, 15) == 0);
      rd_en      = 1'($urandom_range(0, 1));
      rd_bank    = 1'($urandom_range(0, 1));
      rd_chnnl_a = 1'($urandom_range(0, 1));
      rd_chnnl_b = 2'($urandom_range(0, 3));
      rd_addr    = 2'($urandom_range(0, 3));
      tick();
    end
    idle();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
